sel_ctrl: RTL and testbench

SEL_CTRL -- requirements
Module: sel_ctrl

---
 rtl/sel_ctrl.sv | 82 ++++++++
 tb/tb_sel_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sel_ctrl.sv
// Pushbutton-driven select controller: synchronizes and debounces five buttons,
// turns debounced rising edges into up/down/clear/load/lock actions on a 2-bit mux select.
module sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:4] btn,
  input  logic [0:1] sw,
  output logic [0:1] sel,
  output logic       sel_chg,
  output logic [0:4] btn_db,
  output logic       locked
);

  localparam int CW = 20;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [0:4]    r_sync1;
  logic [0:4]    r_sync2;
  logic [CW-1:0] r_cnt [0:4];
  logic [0:4]    r_db;
  logic [0:4]    r_db_q;
  logic [0:1]    r_sel;
  logic          r_chg;
  logic          r_locked;

  logic [0:4]    w_req;
  logic [0:1]    w_sel_nxt;

  // One-cycle request per debounced rising edge; executes on the following edge.
  assign w_req = r_db & ~r_db_q;

  // At most one sel action per cycle, clear > load > up > down; locked uses its
  // pre-toggle value so a lock pressed together with an action does not block it.
  always_comb begin
    w_sel_nxt = r_sel;
    if (!r_locked) begin
      if (w_req[2])      w_sel_nxt = 2'd0;
      else if (w_req[3]) w_sel_nxt = sw;
      else if (w_req[0]) w_sel_nxt = r_sel + 2'd1;
      else if (w_req[1]) w_sel_nxt = r_sel - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_db     <= '0;
      r_db_q   <= '0;
      r_sel    <= '0;
      r_chg    <= 1'b0;
      r_locked <= 1'b0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1  <= btn;
      r_sync2  <= r_sync1;
      r_db_q   <= r_db;
      r_sel    <= w_sel_nxt;
      r_chg    <= (w_sel_nxt != r_sel);
      if (w_req[4]) r_locked <= ~r_locked;
      // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges in a row.
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign sel     = r_sel;
  assign sel_chg = r_chg;
  assign btn_db  = r_db;
  assign locked  = r_locked;

endmodule

// File: tb/tb_sel_ctrl.sv
// Bench for sel_ctrl with DEBOUNCE_CYCLES=4: directed scenarios with literal
// expectations plus randomized button traffic checked every cycle against a reference model.
module tb_sel_ctrl;

  localparam int D = 4;
  localparam logic [0:4] B_UP  = 5'b10000;
  localparam logic [0:4] B_DN  = 5'b01000;
  localparam logic [0:4] B_CLR = 5'b00100;
  localparam logic [0:4] B_LD  = 5'b00010;
  localparam logic [0:4] B_LK  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:4] btn;
  logic [0:1] sw;
  logic [0:1] sel;
  logic       sel_chg;
  logic [0:4] btn_db;
  logic       locked;

  int n_cmp  = 0;
  int n_fail = 0;
  int chg_seen = 0;

  sel_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .sw      (sw),
    .sel     (sel),
    .sel_chg (sel_chg),
    .btn_db  (btn_db),
    .locked  (locked)
  );

  // Clock and reset defaults
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: button seen two edges late, level accepted after D
  // consecutive disagreeing edges, action taken one edge after acceptance.
  int         m_sel;
  bit         m_lock, m_chg, m_valid;
  bit [0:4]   m_s1, m_s2, m_db, m_dbp;
  int         m_run [5];

  always @(posedge clk) begin
    bit [0:4] req;
    int       nsel;
    if (rst) begin
      m_sel = 0; m_lock = 0; m_chg = 0; m_valid = 1;
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
    end else begin
      req  = m_db & ~m_dbp;
      nsel = m_sel;
      if (!m_lock) begin
        if (req[2])      nsel = 0;
        else if (req[3]) nsel = int'(sw);
        else if (req[0]) nsel = (m_sel + 1) % 4;
        else if (req[1]) nsel = (m_sel + 3) % 4;
      end
      m_chg = (nsel != m_sel);
      m_sel = nsel;
      if (req[4]) m_lock = !m_lock;
      m_dbp = m_db;
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_db[i]  = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_sel",     32'(sel),     32'(m_sel));
      check("model_sel_chg", 32'(sel_chg), 32'(m_chg));
      check("model_btn_db",  32'(btn_db),  32'(m_db));
      check("model_locked",  32'(locked),  32'(m_lock));
      if (sel_chg === 1'b1) chg_seen++;
    end
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [0:4] mask);
    btn = mask;
    cycles(D + 4);
    btn = '0;
    cycles(D + 4);
  endtask

  initial begin
    rst = 1'b1; btn = '0; sw = '0;
    cycles(3);
    check("reset_sel",    32'(sel),     0);
    check("reset_chg",    32'(sel_chg), 0);
    check("reset_btn_db", 32'(btn_db),  0);
    check("reset_locked", 32'(locked),  0);

    // Clean press of up: edges counted from deassertion
    rst = 1'b0; btn = B_UP;
    cycles(5);
    check("up_db_edge5", 32'(btn_db[0]), 0);
    cycles(1);
    check("up_db_edge6",  32'(btn_db[0]), 1);
    check("up_sel_edge6", 32'(sel),       0);
    cycles(1);
    check("up_sel_edge7", 32'(sel),     1);
    check("up_chg_edge7", 32'(sel_chg), 1);
    cycles(1);
    check("up_chg_edge8", 32'(sel_chg), 0);
    btn = '0;
    cycles(D + 4);

    // Wrap up from 3, then wrap down from 0
    sw = 2'b11; press(B_LD);
    check("load3", 32'(sel), 3);
    press(B_UP); check("up_wrap", 32'(sel), 0);
    press(B_UP); check("up_1",    32'(sel), 1);
    press(B_UP); check("up_2",    32'(sel), 2);
    press(B_CLR); check("clear", 32'(sel), 0);
    press(B_DN); check("dn_wrap", 32'(sel), 3);
    press(B_DN); check("dn_2",    32'(sel), 2);
    press(B_DN); check("dn_1",    32'(sel), 1);

    // Bounce: high 3 cycles, low 2, five times
    chg_seen = 0;
    for (int k = 0; k < 5; k++) begin
      btn = B_UP; cycles(3);
      btn = '0;   cycles(2);
    end
    cycles(D + 4);
    check("bounce_db",  32'(btn_db), 0);
    check("bounce_sel", 32'(sel),    1);
    check("bounce_chg", 32'(chg_seen), 0);

    // Load beats up; reloading the same value makes no pulse
    sw = 2'b10; press(B_LD | B_UP);
    check("load_wins", 32'(sel), 2);
    chg_seen = 0;
    press(B_LD);
    check("reload_sel", 32'(sel), 2);
    check("reload_chg", 32'(chg_seen), 0);

    // Locked: all sel actions ignored
    press(B_LK);
    check("lock_on", 32'(locked), 1);
    chg_seen = 0;
    sw = 2'b01;
    press(B_UP); press(B_DN); press(B_CLR); press(B_LD);
    check("locked_sel", 32'(sel), 2);
    check("locked_chg", 32'(chg_seen), 0);
    press(B_LK);
    check("lock_off", 32'(locked), 0);
    press(B_UP);
    check("unlocked_up", 32'(sel), 3);
    // Lock and up together: up still uses the old (unlocked) state
    press(B_LK | B_UP);
    check("lock_up_sel",    32'(sel),    0);
    check("lock_up_locked", 32'(locked), 1);
    press(B_LK);
    check("lock_off2", 32'(locked), 0);

    // Reset mid-debounce while down is held
    sw = 2'b10; press(B_LD);
    check("pre_rst_sel", 32'(sel), 2);
    btn = B_DN;
    cycles(4);
    rst = 1'b1;
    cycles(1);
    check("rst_sel",    32'(sel),    0);
    check("rst_locked", 32'(locked), 0);
    check("rst_db",     32'(btn_db), 0);
    rst = 1'b0;
    cycles(D + 2);
    check("post_rst_sel_early", 32'(sel), 0);
    cycles(1);
    check("post_rst_sel", 32'(sel), 3);
    btn = '0;
    cycles(D + 4);

    // Randomized traffic, model-checked every cycle
    for (int k = 0; k < 150; k++) begin
      btn = 5'($urandom_range(0, 31));
      sw  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles($urandom_range(0, 9));
    end
    btn = '0;
    cycles(D + 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
